// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// Holds the controller state encoding and the accumulator mux select codes.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mult_state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_ADD  = 2'b01;
  localparam logic [1:0] SEL_CLR  = 2'b10;

endpackage : mult_pkg

// File: rtl/mux3.sv
// Generic three-input multiplexer with a 2-bit select.
// The unused select code 2'b11 falls back to d0 so the output is always defined.
module mux3 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  // NOTE: y gets a value on every path (default first) so no latch is inferred.
  always_comb begin
    y = d0;
    case (s)
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d0;
    endcase
  end

endmodule : mux3

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-and-add unsigned multiplier: start/done controller,
// shift registers and a mux3-selected accumulator retiring one multiplier bit per cycle.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mult_state_t      state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;

  logic [1:0]       sel;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   nxt;

  // Clear on an accepted start, add when the current multiplier bit is set.
  always_comb begin
    sel = SEL_HOLD;
    if (state == IDLE && start) begin
      sel = SEL_CLR;
    end else if (state == CALC) begin
      sel = {1'b0, lo[0]};
    end
  end

  // The one widening point: the carry out of hi+mcand lives in sum[WIDTH].
  assign sum = {1'b0, hi} + {1'b0, mcand};

  mux3 #(
    .WIDTH (WIDTH + 1)
  ) u_acc_mux (
    .d0 ({1'b0, hi}),
    .d1 (sum),
    .d2 ({(WIDTH + 1){1'b0}}),
    .s  (sel),
    .y  (nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= nxt[WIDTH-1:0];
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          // Shift {carry, hi, lo} right by one: carry enters hi, hi's LSB enters lo.
          hi  <= nxt[WIDTH:1];
          lo  <= {nxt[0], lo[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            // Capture the final {hi,lo} as it is written so product is valid with done.
            product <= {nxt[WIDTH:1], nxt[0], lo[WIDTH-1:1]};
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == CALC) || (state == DONE);
  assign done = (state == DONE);

endmodule : mult_seq

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq at WIDTH=8: latency, carry, zero
// operands, ignored start, back-to-back throughput and mid-operation reset.
module tb_mult_seq;
  import mult_pkg::*;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int tests_run = 0;
  int tests_failed = 0;

  mult_seq #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One operation from a start pulse; optionally re-pulses start in CALC and in DONE.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [2*WIDTH-1:0] exp, input bit poke);
    int n;
    int busy_cnt;
    int extra;
    bit stable;
    logic [2*WIDTH-1:0] prev;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~x; b = ~y;
    check({tag, "_busy_on_accept"}, 32'(busy), 32'd1);
    prev = product; n = 0; busy_cnt = 0; stable = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (product !== prev) stable = 1'b0;
      if (poke && n == 2) begin
        start = 1'b1; a = 8'd9; b = 8'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(WIDTH));
    check({tag, "_product"}, 32'(product), 32'(exp));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH + 1));
    check({tag, "_product_stable"}, 32'(stable), 32'd1);
    if (poke) begin
      start = 1'b1; a = 8'd9; b = 8'd9;
      @(negedge clk);
      start = 1'b0;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        if (busy !== 1'b0 || done !== 1'b0) extra++;
        @(negedge clk);
      end
      check({tag, "_no_second_op"}, 32'(extra), 32'd0);
      check({tag, "_product_held"}, 32'(product), 32'(exp));
    end else begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle_after"}, 32'(busy), 32'd0);
      check({tag, "_product_held"}, 32'(product), 32'(exp));
    end
  endtask

  initial begin
    int n;
    int m;
    bit stable;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;

    run_op("basic_13x11", 8'd13, 8'd11, 16'd143, 1'b0);
    run_op("max_255x255", 8'd255, 8'd255, 16'hFE01, 1'b0);
    run_op("carry_255x128", 8'd255, 8'd128, 16'd32640, 1'b0);
    run_op("zero_0x200", 8'd0, 8'd200, 16'd0, 1'b0);
    run_op("zero_77x0", 8'd77, 8'd0, 16'd0, 1'b0);
    run_op("busy_start_3x5", 8'd3, 8'd5, 16'd15, 1'b1);

    // Back-to-back with start held high; new operands are picked up in the next IDLE.
    @(negedge clk);
    a = 8'd6; b = 8'd7; start = 1'b1;
    @(negedge clk);
    a = 8'd100; b = 8'd3;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_latency", 32'(n), 32'(WIDTH));
    check("b2b_first_product", 32'(product), 32'd42);
    m = 0; stable = 1'b1;
    do begin
      @(negedge clk);
      m++;
      if (done !== 1'b1 && product !== 16'd42) stable = 1'b0;
    end while (done !== 1'b1 && m < 40);
    start = 1'b0;
    check("b2b_done_spacing", 32'(m), 32'(WIDTH + 2));
    check("b2b_first_held", 32'(stable), 32'd1);
    check("b2b_second_product", 32'(product), 32'd300);
    @(negedge clk);
    check("b2b_idle_after", 32'(busy), 32'd0);

    // Reset in the 4th CALC cycle aborts at once and clears the previous product.
    @(negedge clk);
    a = 8'd200; b = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst_2x2", 8'd2, 8'd2, 16'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mult_seq
